adain_sequencer: RTL and testbench
==================================

# adain_sequencer

Frame buffer and two-pass sequencer that sits directly upstream of `top_adain`. It accepts one N×N feature map (Q32.16) over a valid/ready stream and stores it. It then replays the map twice into the AdaIN core: a scan pass (`start=01`) so the core computes its statistics, and a normalize pass (`start=10`) so it produces output. It sequences the core's `en`/`start`/`done` handshake, so the core never sees raw upstream backpressure.

## Interface
- `WIDTH_IN`, 48, pixel and style width (Q32.16).
- `N_MAX`, 128, maximum frame side.
- `PIX_GAP`, 2, idle `en=0` cycles after each `en=1` pixel cycle.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `N` in $clog2(N_MAX+1): frame side, sampled on the first accepted pixel.
- `ys_in`, `yb_in` in WIDTH_IN: style scale and bias, sampled with `N`.
- `s_valid` in 1, `s_ready` out 1, `s_data` in WIDTH_IN: upstream pixel stream, raster order.
- `a_en` out 1, `a_start` out 2, `a_in` out WIDTH_IN, `a_N` out $clog2(N_MAX+1), `a_ys`/`a_yb` out WIDTH_IN: drive the AdaIN core.
- `a_done` in 2: AdaIN core status.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when the frame completes.

## Operation
- FSM states: IDLE, LOAD, SCAN, WAIT_STATS, NORM, WAIT_OUT.
- IDLE
  - `s_ready=1` only when 1 ≤ `N` ≤ `N_MAX`.
  - An accepted beat writes address 0; `N`, `ys_in` and `yb_in` latch into `a_N`, `a_ys` and `a_yb`.
  - Next state is LOAD, or SCAN if `N==1`.
  - Out-of-range `N` holds `s_ready=0`; the block stays in IDLE.
- LOAD
  - `s_ready=1`. Each accepted beat writes the next address.
  - After beat N²−1 is accepted, `s_ready` drops the next cycle and the FSM enters SCAN.
  - `s_valid` gaps are tolerated.
- SCAN: replay addresses 0..N²−1 in slots of (1+`PIX_GAP`) cycles.
  - Slot cycle 0: `a_en=1` and `a_in` = pixel.
  - Remaining slot cycles: `a_en=0`; `a_in` holds its value.
  - `a_start=01` for the whole pass. It returns to 00 on the cycle after the last slot, and the FSM enters WAIT_STATS.
- WAIT_STATS: `a_en=1`, `a_start=00`. Exit to NORM on `a_done==01`.
- NORM: identical to SCAN, with `a_start=10`.
- WAIT_OUT: `a_en=1`. On `a_done==11`, pulse `frame_done` and go to IDLE.
- `s_ready=0` in SCAN, WAIT_STATS, NORM and WAIT_OUT. A new frame cannot be loaded until IDLE.
- `a_done` values other than the awaited code are ignored in every state.
- `a_in` keeps the last pixel after a pass ends; it is not zeroed.
- Arithmetic: address = 0..N²−1 with width $clog2(N_MAX²). N² is computed once, at latch time.

## Timing
- Reset (`rst=0` at a rising edge):
  - State IDLE; all counters 0.
  - `a_en=1`, `a_start=00`, `a_in=0`, `a_N=0`, `a_ys=0`, `a_yb=0`.
  - `busy=0`, `frame_done=0`, `s_ready=0` for that cycle.
- Reset mid-frame has the same effect. Buffer contents are not cleared; the next frame overwrites them.
- Buffer read is synchronous with 1-cycle latency. The read for slot k issues one cycle before that slot's `a_en=1` cycle, so the first slot starts 1 cycle after entering SCAN/NORM.
- Pass length is exactly N²·(1+`PIX_GAP`) cycles of asserted `a_start`.
- Minimum load time is N² cycles, at one beat per cycle.

## Structure
- Shared package `adain_pkg`:
  - `WIDTH_IN`=48, `WIDTH_OUT`=16.
  - Start codes: START_IDLE=2'b00, START_SCAN=2'b01, START_NORM=2'b10.
  - Done codes: DONE_IDLE=00, DONE_STATS=01, DONE_OUT=10, DONE_ALL=11.
  - The FSM state enum.
- Sub-module `adain_pixel_buf`: simple dual-port synchronous RAM, N_MAX²×WIDTH_IN, 1 write port and 1 read port, registered read.

## Test plan
- Basic 2×2 frame: `N=2`, pixels 0x0000_0001_0000..0x0000_0004_0000, `ys`=0x0000_0001_0000, `yb=0`.
  - SCAN: `a_en=1` on cycles t, t+3, t+6, t+9 with `a_in`=1, 2, 3, 4 (Q32.16); `a_start=01` for 12 cycles.
  - NORM: the same sequence after `a_done=01`.
  - `frame_done` pulses 1 cycle after `a_done=11`.
- Backpressure: `N=2` with `s_valid` toggling every other cycle → all 4 beats stored in order; `s_ready=0` from the cycle after beat 3 until IDLE.
- Single pixel: `N=1` → IDLE goes directly to SCAN; exactly one `a_en` pulse per pass.
- Illegal size: `N=0` and `N=N_MAX+1` → `s_ready` stays 0, `busy` stays 0.
- Reset mid-SCAN: drop `rst` at slot 2 → next cycle `a_start=00`, `busy=0`. A fresh frame of values 5..8 then replays exactly 5..8.
- Spurious status: hold `a_done=11` during WAIT_STATS → FSM stays in WAIT_STATS until `a_done=01`.

Source files
------------

// File: rtl/adain_pkg.sv
// Shared constants, handshake codes and sequencer state encoding for the AdaIN datapath.
package adain_pkg;

  localparam int unsigned WIDTH_IN    = 48;
  localparam int unsigned WIDTH_OUT   = 16;
  localparam int unsigned N_MAX_DEF   = 128;
  localparam int unsigned PIX_GAP_DEF = 2;

  localparam logic [1:0] START_IDLE = 2'b00;
  localparam logic [1:0] START_SCAN = 2'b01;
  localparam logic [1:0] START_NORM = 2'b10;

  localparam logic [1:0] DONE_IDLE  = 2'b00;
  localparam logic [1:0] DONE_STATS = 2'b01;
  localparam logic [1:0] DONE_OUT   = 2'b10;
  localparam logic [1:0] DONE_ALL   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_WAIT_STATS,
    ST_NORM,
    ST_WAIT_OUT
  } seq_state_e;

endpackage

// File: rtl/adain_sequencer_if.sv
// Upstream pixel stream plus AdaIN core control bundle seen by adain_sequencer.
interface adain_sequencer_if #(
  parameter int unsigned WIDTH_IN = adain_pkg::WIDTH_IN,
  parameter int unsigned N_MAX    = adain_pkg::N_MAX_DEF
);
  localparam int unsigned NW = $clog2(N_MAX + 1);

  logic [NW-1:0]       N;
  logic [WIDTH_IN-1:0] ys_in;
  logic [WIDTH_IN-1:0] yb_in;
  logic                s_valid;
  logic                s_ready;
  logic [WIDTH_IN-1:0] s_data;

  logic                a_en;
  logic [1:0]          a_start;
  logic [WIDTH_IN-1:0] a_in;
  logic [NW-1:0]       a_N;
  logic [WIDTH_IN-1:0] a_ys;
  logic [WIDTH_IN-1:0] a_yb;
  logic [1:0]          a_done;

  logic                busy;
  logic                frame_done;

  // Environment side: pixel producer and AdaIN core.
  modport master (
    output N, ys_in, yb_in, s_valid, s_data, a_done,
    input  s_ready, a_en, a_start, a_in, a_N, a_ys, a_yb, busy, frame_done
  );

  // Sequencer side.
  modport slave (
    input  N, ys_in, yb_in, s_valid, s_data, a_done,
    output s_ready, a_en, a_start, a_in, a_N, a_ys, a_yb, busy, frame_done
  );
endinterface

// File: rtl/adain_pixel_buf.sv
// Simple dual-port frame store: one write port, one read port with a registered read.
module adain_pixel_buf #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Storage itself is never reset; a new frame simply overwrites it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on a read, so it holds between pixel slots.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adain_sequencer.sv
// Stores one NxN frame and replays it into top_adain twice (scan, then normalize),
// spacing pixels by PIX_GAP idle cycles and sequencing the core's start/done handshake.
module adain_sequencer #(
  parameter int unsigned WIDTH_IN = adain_pkg::WIDTH_IN,
  parameter int unsigned N_MAX    = adain_pkg::N_MAX_DEF,
  parameter int unsigned PIX_GAP  = adain_pkg::PIX_GAP_DEF
) (
  input logic             clk,
  input logic             rst,
  adain_sequencer_if.slave bus
);
  import adain_pkg::*;

  localparam int unsigned NW    = $clog2(N_MAX + 1);
  localparam int unsigned DEPTH = N_MAX * N_MAX;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = 2 * NW;
  localparam int unsigned TW    = (PIX_GAP > 0) ? $clog2(PIX_GAP + 1) : 1;

  seq_state_e          state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       last_q, last_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic                lead_q, lead_d;

  logic                s_ready_q, s_ready_d;
  logic                a_en_q, a_en_d;
  logic [1:0]          a_start_q, a_start_d;
  logic [NW-1:0]       a_n_q, a_n_d;
  logic [WIDTH_IN-1:0] a_ys_q, a_ys_d;
  logic [WIDTH_IN-1:0] a_yb_q, a_yb_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic                n_ok_c, accept_c, pass_c, slot_end_c, pass_end_c, enter_pass_c;
  logic [PW-1:0]       sq_c;
  logic [AW-1:0]       last_c;
  logic [1:0]          code_c;
  logic                wr_en_c, rd_en_c;
  logic [AW-1:0]       wr_addr_c, rd_addr_c;
  logic [WIDTH_IN-1:0] rdata_c;

  // Frame geometry and handshake qualifiers.
  assign n_ok_c     = (bus.N != '0) && (bus.N <= NW'(N_MAX));
  assign accept_c   = bus.s_valid && s_ready_q && ((state_q != ST_IDLE) || n_ok_c);
  assign sq_c       = PW'(bus.N) * PW'(bus.N);
  assign last_c     = AW'(sq_c - PW'(1));
  assign pass_c     = (state_q == ST_SCAN) || (state_q == ST_NORM);
  assign slot_end_c = pass_c && !lead_q && (tick_q == TW'(PIX_GAP));
  assign pass_end_c = slot_end_c && (addr_q == last_q);
  assign code_c     = (state_q == ST_NORM) ? START_NORM : START_SCAN;
  assign enter_pass_c = ((state_d == ST_SCAN) && (state_q != ST_SCAN)) ||
                        ((state_d == ST_NORM) && (state_q != ST_NORM));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (accept_c) state_d = (bus.N == NW'(1)) ? ST_SCAN : ST_LOAD;
      ST_LOAD:       if (accept_c && (addr_q == last_q)) state_d = ST_SCAN;
      ST_SCAN:       if (pass_end_c) state_d = ST_WAIT_STATS;
      ST_WAIT_STATS: if (bus.a_done == DONE_STATS) state_d = ST_NORM;
      ST_NORM:       if (pass_end_c) state_d = ST_WAIT_OUT;
      ST_WAIT_OUT:   if (bus.a_done == DONE_ALL) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Counters, buffer control and registered outputs.
  always_comb begin
    addr_d    = addr_q;
    last_d    = last_q;
    tick_d    = tick_q;
    lead_d    = lead_q;
    a_n_d     = a_n_q;
    a_ys_d    = a_ys_q;
    a_yb_d    = a_yb_q;
    wr_en_c   = 1'b0;
    wr_addr_c = addr_q;
    rd_en_c   = 1'b0;
    rd_addr_c = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          wr_en_c   = 1'b1;
          wr_addr_c = '0;
          addr_d    = AW'(1);
          last_d    = last_c;
          a_n_d     = bus.N;
          a_ys_d    = bus.ys_in;
          a_yb_d    = bus.yb_in;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          wr_en_c = 1'b1;
          addr_d  = addr_q + AW'(1);
        end
      end
      ST_SCAN, ST_NORM: begin
        // Read for the next slot issues on the last cycle of the current one.
        if (lead_q) begin
          rd_en_c = 1'b1;
          lead_d  = 1'b0;
          tick_d  = '0;
        end else if (slot_end_c) begin
          tick_d = '0;
          if (!pass_end_c) begin
            rd_en_c   = 1'b1;
            rd_addr_c = addr_q + AW'(1);
            addr_d    = addr_q + AW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: ;
    endcase

    if (enter_pass_c) begin
      addr_d = '0;
      lead_d = 1'b1;
      tick_d = '0;
    end

    s_ready_d    = (state_d == ST_LOAD) || ((state_d == ST_IDLE) && n_ok_c);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_q == ST_WAIT_OUT) && (bus.a_done == DONE_ALL);
    a_en_d       = !(pass_c && !lead_q && !slot_end_c);
    a_start_d    = (pass_c && !pass_end_c) ? code_c : START_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      last_q       <= '0;
      tick_q       <= '0;
      lead_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      a_en_q       <= 1'b1;
      a_start_q    <= START_IDLE;
      a_n_q        <= '0;
      a_ys_q       <= '0;
      a_yb_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      last_q       <= last_d;
      tick_q       <= tick_d;
      lead_q       <= lead_d;
      s_ready_q    <= s_ready_d;
      a_en_q       <= a_en_d;
      a_start_q    <= a_start_d;
      a_n_q        <= a_n_d;
      a_ys_q       <= a_ys_d;
      a_yb_q       <= a_yb_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  adain_pixel_buf #(
    .WIDTH (WIDTH_IN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_c),
    .waddr (wr_addr_c),
    .wdata (bus.s_data),
    .re    (rd_en_c),
    .raddr (rd_addr_c),
    .rdata (rdata_c)
  );

  assign bus.s_ready    = s_ready_q;
  assign bus.a_en       = a_en_q;
  assign bus.a_start    = a_start_q;
  assign bus.a_in       = rdata_c;
  assign bus.a_N        = a_n_q;
  assign bus.a_ys       = a_ys_q;
  assign bus.a_yb       = a_yb_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_adain_sequencer.sv
// Directed bench for adain_sequencer: scoreboard of expected core pixel slots and pass lengths.
module tb_adain_sequencer;
  import adain_pkg::*;

  localparam int unsigned NW = 8;

  typedef struct packed {
    logic [1:0]  code;
    logic [47:0] pix;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  adain_sequencer_if #(.WIDTH_IN(48), .N_MAX(128)) bus ();

  adain_sequencer #(.WIDTH_IN(48), .N_MAX(128), .PIX_GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   len_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;
  int   run_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] pix(input int v);
    return 48'(v) << 16;
  endfunction

  // Monitor: pops one expectation per presented pixel slot, one length per pass.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.a_en && (bus.a_start != START_IDLE)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_slot", {14'd0, bus.a_start, bus.a_in}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_code", 64'(bus.a_start), 64'(mon_e.code));
          chk("sb_pixel", 64'(bus.a_in), 64'(mon_e.pix));
        end
      end
      if (bus.a_start != START_IDLE) begin
        run_len++;
      end else if (run_len > 0) begin
        if (len_q.size() == 0) chk("sb_unexpected_pass", 64'(run_len), 64'd0);
        else                   chk("sb_pass_len", 64'(run_len), 64'(len_q.pop_front()));
        run_len = 0;
      end
    end
  end

  task automatic load_frame(input int n, input int first, input logic [47:0] ys,
                            input logic [47:0] yb, input bit gappy);
    int w;
    bus.N     = NW'(n);
    bus.ys_in = ys;
    bus.yb_in = yb;
    for (int i = 0; i < n * n; i++) begin
      if (gappy && i > 0) begin
        bus.s_valid = 1'b0;
        tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = pix(first + i);
      w = 0;
      while (!bus.s_ready && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) chk("load_ready_timeout", 64'(w), 64'd0);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("ready_drop_after_last", 64'(bus.s_ready), 64'd0);
    chk("busy_after_load", 64'(bus.busy), 64'd1);
    chk("a_N_latched", 64'(bus.a_N), 64'(n));
    chk("a_ys_latched", 64'(bus.a_ys), 64'(ys));
    chk("a_yb_latched", 64'(bus.a_yb), 64'(yb));
  endtask

  task automatic wait_pass(input logic [1:0] code);
    int w    = 0;
    bit seen = 1'b0;
    bit rdy  = 1'b0;
    while (w < 500) begin
      if (bus.s_ready) rdy = 1'b1;
      if (bus.a_start == code) seen = 1'b1;
      else if (seen) break;
      tick();
      w++;
    end
    chk("pass_timeout", 64'(w >= 500), 64'd0);
    chk("ready_low_in_pass", 64'(rdy), 64'd0);
  endtask

  task automatic run_frame(input int n, input int first, input logic [47:0] ys,
                           input logic [47:0] yb, input bit gappy, input bit spurious);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < n * n; i++)
        exp_q.push_back('{code: (p == 0) ? START_SCAN : START_NORM, pix: pix(first + i)});
      len_q.push_back(3 * n * n);
    end
    load_frame(n, first, ys, yb, gappy);
    wait_pass(START_SCAN);
    if (spurious) begin
      bus.a_done = DONE_ALL;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("spurious_start_idle", 64'(bus.a_start), 64'(START_IDLE));
        chk("spurious_busy", 64'(bus.busy), 64'd1);
        chk("spurious_no_done", 64'(bus.frame_done), 64'd0);
      end
    end
    bus.a_done = DONE_STATS;
    tick();
    bus.a_done = DONE_IDLE;
    wait_pass(START_NORM);
    chk("wait_out_en", 64'(bus.a_en), 64'd1);
    bus.a_done = DONE_ALL;
    tick();
    bus.a_done = DONE_IDLE;
    chk("frame_done_pulse", 64'(bus.frame_done), 64'd1);
    chk("busy_back_idle", 64'(bus.busy), 64'd0);
    tick();
    chk("frame_done_clear", 64'(bus.frame_done), 64'd0);
  endtask

  initial begin
    int cnt;
    int w;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.N       = '0;
    bus.ys_in   = '0;
    bus.yb_in   = '0;
    bus.a_done  = DONE_IDLE;
    repeat (2) tick();

    chk("rst_a_en", 64'(bus.a_en), 64'd1);
    chk("rst_a_start", 64'(bus.a_start), 64'd0);
    chk("rst_a_in", 64'(bus.a_in), 64'd0);
    chk("rst_a_N", 64'(bus.a_N), 64'd0);
    chk("rst_a_ys", 64'(bus.a_ys), 64'd0);
    chk("rst_a_yb", 64'(bus.a_yb), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);

    rst    = 1'b1;
    mon_en = 1'b1;

    // Illegal sizes: N=0 and N=N_MAX+1.
    bus.s_valid = 1'b1;
    bus.s_data  = pix(99);
    repeat (3) tick();
    chk("n0_s_ready", 64'(bus.s_ready), 64'd0);
    chk("n0_busy", 64'(bus.busy), 64'd0);
    bus.N = NW'(129);
    repeat (3) tick();
    chk("n129_s_ready", 64'(bus.s_ready), 64'd0);
    chk("n129_busy", 64'(bus.busy), 64'd0);
    bus.s_valid = 1'b0;
    tick();

    // Basic 2x2, backpressured 2x2 with spurious status, single pixel.
    run_frame(2, 1, 48'h0000_0001_0000, 48'h0, 1'b0, 1'b0);
    run_frame(2, 9, 48'h0000_0002_0000, 48'h0000_0000_0003, 1'b1, 1'b1);
    run_frame(1, 13, 48'h0000_0003_0000, 48'h0000_0000_8000, 1'b0, 1'b0);

    // Reset during slot 2 of a scan pass.
    for (int i = 0; i < 3; i++) exp_q.push_back('{code: START_SCAN, pix: pix(21 + i)});
    len_q.push_back(7);
    load_frame(2, 21, 48'h0000_0001_0000, 48'h0, 1'b0);
    cnt = 0;
    w   = 0;
    while (w < 100) begin
      if (bus.a_en && bus.a_start == START_SCAN) cnt++;
      if (cnt == 3) break;
      tick();
      w++;
    end
    chk("slot2_reached", 64'(cnt), 64'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_a_start", 64'(bus.a_start), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_a_en", 64'(bus.a_en), 64'd1);
    chk("midrst_a_in", 64'(bus.a_in), 64'd0);
    chk("midrst_a_N", 64'(bus.a_N), 64'd0);

    run_frame(2, 5, 48'h0000_0001_0000, 48'h0, 1'b0, 1'b0);

    repeat (3) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("len_drained", 64'(len_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
